// File: rtl/osc_timebase_decim_if.sv
// Sample/config/strobe bundle between the ADC front end, the timebase decimator
// and the trigger stage.
interface osc_timebase_decim_if #(
  parameter int unsigned DIVW = 24,
  parameter int unsigned SHW  = 4
);
  logic signed [7:0] adc_din;
  logic              adc_valid;
  logic              cfg_ld;
  logic [DIVW-1:0]   div;
  logic [SHW-1:0]    sh;
  logic [1:0]        mode;
  logic signed [7:0] dout;
  logic              en;

  modport master (
    output adc_din, adc_valid, cfg_ld, div, sh, mode,
    input  dout, en
  );

  modport slave (
    input  adc_din, adc_valid, cfg_ld, div, sh, mode,
    output dout, en
  );
endinterface

// File: rtl/osc_timebase_decim.sv
// Oscilloscope timebase decimator: plain sample, power-of-two average or
// alternating max/min peak over a programmable window of valid ADC samples.
module osc_timebase_decim #(
  parameter int unsigned DIVW = 24,
  parameter int unsigned SHW  = 4,
  parameter int unsigned ACCW = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  osc_timebase_decim_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_SAMPLE = 2'd0,
    MODE_AVG    = 2'd1,
    MODE_PEAK   = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic {
    PH_MAX = 1'b0,
    PH_MIN = 1'b1
  } phase_e;

  logic [DIVW-1:0]          div_q, div_d, div_e;
  logic [SHW-1:0]           sh_q, sh_d, sh_e;
  mode_e                    mode_q, mode_d, mode_e_w;
  logic [DIVW-1:0]          cnt_q, cnt_d, cnt_c, last_idx;
  logic signed [ACCW-1:0]   acc_q, acc_d, acc_sum, din_x;
  logic signed [7:0]        pk_q, pk_d, pk_nx, avg_res;
  phase_e                   phase_q, phase_d, phase_c;
  logic signed [7:0]        dout_q, dout_d;
  logic                     en_q, en_d;
  logic                     first;

  assign bus.dout = dout_q;
  assign bus.en   = en_q;

  // A cfg_ld cycle runs its own sample under the new config with a fresh window,
  // so the "effective" config/count/phase below already include the load.
  always_comb begin
    div_e    = bus.cfg_ld ? bus.div : div_q;
    sh_e     = bus.cfg_ld ? bus.sh  : sh_q;
    mode_e_w = bus.cfg_ld ? mode_e'(bus.mode) : mode_q;
    cnt_c    = bus.cfg_ld ? '0 : cnt_q;
    phase_c  = bus.cfg_ld ? PH_MAX : phase_q;

    first    = (cnt_c == '0);
    din_x    = {{(ACCW-8){bus.adc_din[7]}}, bus.adc_din};
    acc_sum  = first ? din_x : acc_q + din_x;
    avg_res  = 8'(acc_sum >>> sh_e);

    if (first)
      pk_nx = bus.adc_din;
    else if (phase_c == PH_MAX)
      pk_nx = (bus.adc_din > pk_q) ? bus.adc_din : pk_q;
    else
      pk_nx = (bus.adc_din < pk_q) ? bus.adc_din : pk_q;

    last_idx = (mode_e_w == MODE_AVG) ? ((DIVW'(1) << sh_e) - DIVW'(1)) : div_e;

    div_d   = div_e;
    sh_d    = sh_e;
    mode_d  = mode_e_w;
    cnt_d   = cnt_c;
    phase_d = phase_c;
    acc_d   = bus.cfg_ld ? '0 : acc_q;
    pk_d    = pk_q;
    dout_d  = dout_q;
    en_d    = 1'b0;

    if (bus.adc_valid) begin
      acc_d = acc_sum;
      pk_d  = pk_nx;
      if (cnt_c == last_idx) begin
        cnt_d   = '0;
        en_d    = 1'b1;
        phase_d = (phase_c == PH_MAX) ? PH_MIN : PH_MAX;
        case (mode_e_w)
          MODE_AVG:  dout_d = avg_res;
          MODE_PEAK: dout_d = pk_nx;
          default:   dout_d = bus.adc_din;
        endcase
      end else begin
        cnt_d = cnt_c + DIVW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      sh_q    <= '0;
      mode_q  <= MODE_SAMPLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      pk_q    <= '0;
      phase_q <= PH_MAX;
      dout_q  <= '0;
      en_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      sh_q    <= sh_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      pk_q    <= pk_d;
      phase_q <= phase_d;
      dout_q  <= dout_d;
      en_q    <= en_d;
    end
  end

endmodule

// File: tb/tb_osc_timebase_decim.sv
// Bench for osc_timebase_decim: window-level reference model compared every
// cycle, plus directed scenarios with literal expected strobes.
module tb_osc_timebase_decim;

  logic clk;
  logic rst;

  osc_timebase_decim_if #(.DIVW(24), .SHW(4)) bus ();

  osc_timebase_decim #(.DIVW(24), .SHW(4), .ACCW(23)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: collect the window's samples, reduce when it is full.
  int      win[$];
  longint  m_div;
  int      m_sh, m_mode, m_phase;
  int      exp_en, exp_dout;
  bit      started = 0;
  int      cyc_n = 0;

  initial begin
    forever begin
      longint wlen;
      int     r, sum, d;
      @(posedge clk);
      cyc_n++;
      if (rst) begin
        win.delete();
        m_div = 0; m_sh = 0; m_mode = 0; m_phase = 0;
        exp_en = 0; exp_dout = 0;
        started = 1;
      end else begin
        exp_en = 0;
        if (bus.cfg_ld) begin
          m_div = longint'(bus.div); m_sh = int'(bus.sh); m_mode = int'(bus.mode);
          win.delete();
          m_phase = 0;
        end
        if (bus.adc_valid) begin
          win.push_back(int'(bus.adc_din));
          wlen = (m_mode == 1) ? (longint'(1) << m_sh) : m_div + 1;
          if (longint'(win.size()) == wlen) begin
            if (m_mode == 1) begin
              sum = 0;
              foreach (win[i]) sum += win[i];
              d = 1 << m_sh;
              r = sum / d;
              if ((sum % d) != 0 && sum < 0) r -= 1;
            end else if (m_mode == 2) begin
              r = win[0];
              foreach (win[i])
                if (m_phase == 0 ? (win[i] > r) : (win[i] < r)) r = win[i];
            end else begin
              r = win[win.size()-1];
            end
            exp_en = 1;
            exp_dout = r;
            win.delete();
            m_phase ^= 1;
          end
        end
      end
    end
  end

  typedef struct { int cyc; int val; } strobe_t;
  strobe_t strobes[$];

  always @(negedge clk) begin
    if (started) begin
      chk("en", int'(bus.en), exp_en);
      chk("dout", int'(bus.dout), exp_dout);
      if (bus.en) strobes.push_back('{cyc_n, int'(bus.dout)});
    end
  end

  task automatic tick(input bit v, input int d);
    bus.adc_valid = v;
    bus.adc_din   = 8'(d);
    if (!bus.cfg_ld) begin
      bus.div  = 24'($urandom);
      bus.sh   = 4'($urandom);
      bus.mode = 2'($urandom);
    end
    @(negedge clk);
    bus.cfg_ld = 1'b0;
    rst = 1'b0;
  endtask

  task automatic load(input int dv, input int s, input int m, input bit v, input int d);
    bus.div    = 24'(dv);
    bus.sh     = 4'(s);
    bus.mode   = 2'(m);
    bus.cfg_ld = 1'b1;
    tick(v, d);
  endtask

  task automatic idle2();
    tick(0, 0);
    tick(0, 0);
  endtask

  task automatic chk_strobes(input string name, input int n, input int v0, input int v1, input int v2);
    int exp_v[3];
    exp_v[0] = v0; exp_v[1] = v1; exp_v[2] = v2;
    chk({name, "_count"}, strobes.size(), n);
    for (int i = 0; i < n && i < 3 && i < strobes.size(); i++)
      chk({name, "_val"}, strobes[i].val, exp_v[i]);
  endtask

  initial begin
    rst = 1'b1;
    bus.cfg_ld = 1'b0; bus.adc_valid = 1'b0; bus.adc_din = '0;
    bus.div = '0; bus.sh = '0; bus.mode = '0;
    tick(0, 0);
    chk("rst_dout", int'(bus.dout), 0);
    chk("rst_en", int'(bus.en), 0);

    // W=1 pass-through
    strobes.delete();
    load(0, 0, 0, 1, 1);
    for (int i = 2; i <= 5; i++) tick(1, i);
    idle2();
    chk("t1_count", strobes.size(), 5);
    for (int i = 0; i < 5 && i < strobes.size(); i++) begin
      chk("t1_val", strobes[i].val, i + 1);
      if (i > 0) chk("t1_gap", strobes[i].cyc - strobes[i-1].cyc, 1);
    end

    // SAMPLE div=3
    strobes.delete();
    load(3, 0, 0, 1, 0);
    for (int i = 1; i <= 11; i++) tick(1, i);
    idle2();
    chk_strobes("t2", 3, 3, 7, 11);
    for (int i = 1; i < strobes.size(); i++)
      chk("t2_gap", strobes[i].cyc - strobes[i-1].cyc, 4);

    // AVG sh=2
    strobes.delete();
    load(0, 2, 1, 1, 4);
    tick(1, 5); tick(1, 6); tick(1, -7);
    tick(1, -1); tick(1, -1); tick(1, -1); tick(1, -2);
    idle2();
    chk_strobes("t3", 2, 2, -2, 0);

    // AVG sh=15, all -128
    strobes.delete();
    load(0, 15, 1, 1, -128);
    for (int i = 1; i < 32768; i++) tick(1, -128);
    idle2();
    chk_strobes("t3b", 1, -128, 0, 0);

    // PEAK div=3: MAX, MIN, MAX
    strobes.delete();
    load(3, 0, 2, 1, 1);
    tick(1, -5); tick(1, 9); tick(1, 2);
    tick(1, 3); tick(1, -8); tick(1, 0); tick(1, 4);
    tick(1, 0); tick(1, 0); tick(1, 0); tick(1, 1);
    idle2();
    chk_strobes("t4", 3, 9, -8, 1);

    // div=1 with valid every 3rd clock
    strobes.delete();
    load(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      tick(1, 10 + i);
      tick(0, 0);
      tick(0, 0);
    end
    chk_strobes("t5", 3, 11, 13, 15);

    // Partial window discarded by cfg_ld
    load(3, 0, 0, 1, 20);
    tick(1, 21);
    strobes.delete();
    load(1, 0, 0, 1, 50);
    tick(1, 60);
    idle2();
    chk_strobes("t6", 1, 60, 0, 0);

    // Partial window discarded by rst, rst beating a simultaneous cfg_ld
    load(3, 0, 0, 1, 20);
    tick(1, 21);
    strobes.delete();
    rst = 1'b1;
    bus.div = 24'd5; bus.sh = 4'd3; bus.mode = 2'd1; bus.cfg_ld = 1'b1;
    tick(1, 99);
    chk("t6b_dout", int'(bus.dout), 0);
    chk("t6b_en", int'(bus.en), 0);
    tick(1, 77);
    idle2();
    chk_strobes("t6b", 1, 77, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 299) == 0) rst = 1'b1;
      if ($urandom_range(0, 29) == 0) begin
        bus.div    = 24'($urandom_range(0, 6));
        bus.sh     = 4'($urandom_range(0, 4));
        bus.mode   = 2'($urandom_range(0, 3));
        bus.cfg_ld = 1'b1;
      end
      tick($urandom_range(0, 9) < 7, $urandom_range(0, 255) - 128);
    end
    idle2();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
